// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, error codes, keyboard
// command/reply bytes and LED mask bit positions.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_WAIT_FIRST,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ERROR
  } tx_state_t;

  localparam logic [1:0] ERR_START = 2'd1;
  localparam logic [1:0] ERR_XFER  = 2'd2;
  localparam logic [1:0] ERR_NOACK = 2'd3;

  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] REPLY_ACK    = 8'hFA;
  localparam logic [7:0] REPLY_RESEND = 8'hFE;

  localparam int unsigned LED_SCROLL = 0;
  localparam int unsigned LED_NUM    = 1;
  localparam int unsigned LED_CAPS   = 2;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a
// falling-edge strobe on the synchronized clock.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Idle bus is pulled high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_ff   <= '1;
      data_ff  <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk_i};
      data_ff  <= {data_ff[0], ps2_data_i};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_s    = clk_ff[1];
  assign data_s   = data_ff[1];
  assign clk_fall = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: request-to-send, bit shifting on
// device falling edges, ACK check, with start and transfer timeouts.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC   = 4000,
  parameter int unsigned START_TMO_CYC = 600000,
  parameter int unsigned XFER_TMO_CYC  = 80000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_write,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] tx_err_code
);

  localparam int unsigned TMO_MAX = (START_TMO_CYC > XFER_TMO_CYC) ? START_TMO_CYC : XFER_TMO_CYC;
  localparam int unsigned CNT_MAX = (TMO_MAX > INHIBIT_CYC) ? TMO_MAX : INHIBIT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic clk_s;
  logic data_s;
  logic clk_fall;

  ps2_line_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_s      (clk_s),
    .data_s     (data_s),
    .clk_fall   (clk_fall)
  );

  tx_state_t        state;
  logic [8:0]       shift;
  logic [3:0]       bitcnt;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      shift       <= '0;
      bitcnt      <= '0;
      cnt         <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      tx_err_code <= '0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (tx_write) begin
            shift      <= {odd_parity(tx_data), tx_data};
            tx_busy    <= 1'b1;
            cnt        <= '0;
            bitcnt     <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= ST_INHIBIT;
          end
        end

        // Start bit goes out one cycle before the clock is released so the
        // clock line stays low for exactly INHIBIT_CYC cycles.
        ST_INHIBIT: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(INHIBIT_CYC - 2))
            ps2_data_oe <= 1'b1;
          if (cnt == CNT_W'(INHIBIT_CYC - 1)) begin
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
            state      <= ST_WAIT_FIRST;
          end
        end

        ST_WAIT_FIRST: begin
          if (clk_fall) begin
            ps2_data_oe <= ~shift[0];
            shift       <= shift >> 1;
            bitcnt      <= 4'd1;
            cnt         <= '0;
            state       <= ST_SEND;
          end else if (cnt == CNT_W'(START_TMO_CYC - 1)) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_error    <= 1'b1;
            tx_err_code <= ERR_START;
            state       <= ST_ERROR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
          if (cnt == CNT_W'(XFER_TMO_CYC - 1)) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_error    <= 1'b1;
            tx_err_code <= ERR_XFER;
            state       <= ST_ERROR;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (state == ST_SEND && clk_fall) begin
              if (bitcnt == 4'd9) begin
                ps2_data_oe <= 1'b0;
                bitcnt      <= 4'd10;
                state       <= ST_ACK;
              end else begin
                ps2_data_oe <= ~shift[0];
                shift       <= shift >> 1;
                bitcnt      <= bitcnt + 4'd1;
              end
            end else if (state == ST_ACK && clk_fall) begin
              if (!data_s) begin
                state <= ST_WAIT_IDLE;
              end else begin
                ps2_data_oe <= 1'b0;
                tx_error    <= 1'b1;
                tx_err_code <= ERR_NOACK;
                state       <= ST_ERROR;
              end
            end else if (state == ST_WAIT_IDLE && clk_s && data_s) begin
              tx_done <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end

        ST_DONE, ST_ERROR: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_busy     <= 1'b0;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on an open-drain bus, with
// expected frames and done/error responses checked through queues.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH  = 40;
  localparam int unsigned STMO = 600;
  localparam int unsigned XTMO = 800;
  localparam int unsigned H    = 20;

  typedef struct packed {
    logic       err;
    logic [1:0] code;
  } resp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data = '0;
  logic       tx_write = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic [1:0] tx_err_code;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       clk_line, data_line;

  assign clk_line  = dev_clk & ~ps2_clk_oe;
  assign data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYC   (INH),
    .START_TMO_CYC (STMO),
    .XFER_TMO_CYC  (XTMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_i   (clk_line),
    .ps2_data_i  (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_data     (tx_data),
    .tx_write    (tx_write),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .tx_err_code (tx_err_code)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  resp_t       resp_q[$];
  logic [10:0] frame_q[$];

  int unsigned t_err = 0, t_release = 0, t_first = 0;
  int unsigned oe_len = 0, inh_len = 0;
  logic        rel_data_oe = 1'b0;
  logic        prev_clk_oe = 1'b0, prev_data_oe = 1'b0;
  logic        chk_next = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Response monitor: every done/error pulse must match the next queued response.
  always @(negedge clk) begin
    resp_t e;
    if (chk_next) begin
      check("busy_after_pulse", 32'(tx_busy), 32'd0);
      check("pulse_one_cycle", 32'(tx_done | tx_error), 32'd0);
      chk_next = 1'b0;
    end else if (tx_done || tx_error) begin
      check("done_error_exclusive", 32'(tx_done & tx_error), 32'd0);
      if (tx_error) t_err = cyc;
      if (resp_q.size() == 0) begin
        fail_now("unexpected_pulse", $sformatf("done=%0b error=%0b, expected no pulse", tx_done, tx_error));
      end else begin
        e = resp_q.pop_front();
        check("resp_error_flag", 32'(tx_error), 32'(e.err));
        if (e.err) check("err_code", 32'(tx_err_code), 32'(e.code));
        check("busy_during_pulse", 32'(tx_busy), 32'd1);
      end
      chk_next = 1'b1;
    end
    if (ps2_clk_oe) begin
      oe_len++;
    end else if (prev_clk_oe) begin
      inh_len     = oe_len;
      oe_len      = 0;
      t_release   = cyc;
      rel_data_oe = ps2_data_oe & prev_data_oe;
    end
    prev_clk_oe  = ps2_clk_oe;
    prev_data_oe = ps2_data_oe;
  end

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_write = 1'b1;
    @(negedge clk);
    tx_write = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned limit);
    int unsigned t = 0;
    while (tx_busy && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (tx_busy) fail_now("busy_timeout", $sformatf("tx_busy still 1 after %0d cycles, required 0", limit));
  endtask

  // Device: waits for request-to-send, then issues nclk clocks; clock 11 is the ACK clock.
  task automatic dev_model(input int unsigned nclk, input logic ack);
    logic [10:0] cap = '0;
    logic [10:0] exp_frame;
    int unsigned t = 0;
    while (!ps2_clk_oe && t < 50) begin @(negedge clk); t++; end
    if (!ps2_clk_oe) begin fail_now("dev_request", "clk_oe never asserted"); return; end
    t = 0;
    while (ps2_clk_oe && t < INH + 50) begin @(negedge clk); t++; end
    if (ps2_clk_oe) begin fail_now("dev_release", "clk_oe never released"); return; end
    if (nclk == 0) return;
    repeat (H) @(negedge clk);
    cap[0] = data_line;
    for (int unsigned i = 1; i <= nclk; i++) begin
      if (i == 11) begin
        dev_data = ~ack;
        repeat (H / 2) @(negedge clk);
      end
      dev_clk = 1'b0;
      if (i == 1) t_first = cyc;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) cap[i] = data_line;
      repeat (H) @(negedge clk);
    end
    dev_data = 1'b1;
    if (nclk == 11) begin
      if (frame_q.size() == 0) begin
        fail_now("frame_unexpected", $sformatf("captured %b with nothing expected", cap));
      end else begin
        exp_frame = frame_q.pop_front();
        check("frame", 32'(cap), 32'(exp_frame));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [7:0]  b2b_byte [2];
  logic [10:0] b2b_frame[2];
  int unsigned quiet;

  initial begin
    b2b_byte[0] = 8'h02;     b2b_frame[0] = 11'b1_0_00000010_0;
    b2b_byte[1] = CMD_RESET; b2b_frame[1] = 11'b1_1_11111111_0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_error", 32'(tx_error), 32'd0);
    check("rst_err_code", 32'(tx_err_code), 32'd0);

    // 0xED: data 1,0,1,1,0,1,1,1 LSB first, odd parity 1
    frame_q.push_back(11'b1_1_11101101_0);
    resp_q.push_back('{err: 1'b0, code: 2'd0});
    fork
      write_byte(CMD_SET_LED);
      dev_model(11, 1'b1);
    join
    wait_idle(3000);
    check("inhibit_len", inh_len, INH);
    check("start_before_release", 32'(rel_data_oe), 32'd1);

    for (int unsigned k = 0; k < 2; k++) begin
      frame_q.push_back(b2b_frame[k]);
      resp_q.push_back('{err: 1'b0, code: 2'd0});
      fork
        write_byte(b2b_byte[k]);
        dev_model(11, 1'b1);
      join
      wait_idle(3000);
    end

    // Silent device: start timeout counted from clock release
    resp_q.push_back('{err: 1'b1, code: 2'd1});
    fork
      write_byte(CMD_ENABLE);
      dev_model(0, 1'b0);
    join
    wait_idle(STMO + 200);
    check("start_tmo_cycles", t_err - t_release, STMO);
    check("start_tmo_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("start_tmo_data_oe", 32'(ps2_data_oe), 32'd0);

    // No ACK: data left high at the 11th clock
    frame_q.push_back(11'b1_0_11110100_0);
    resp_q.push_back('{err: 1'b1, code: 2'd3});
    fork
      write_byte(CMD_ENABLE);
      dev_model(11, 1'b0);
    join
    wait_idle(3000);

    // Device stalls after 5 clocks; 3 extra cycles are sync + edge detect latency
    resp_q.push_back('{err: 1'b1, code: 2'd2});
    fork
      write_byte(8'hA5);
      dev_model(5, 1'b1);
    join
    wait_idle(XTMO + 500);
    check("xfer_tmo_cycles", t_err - t_first, XTMO + 3);

    // tx_write mid-SEND must not alter the byte on the wire or start a new transfer
    frame_q.push_back(11'b1_0_11110100_0);
    resp_q.push_back('{err: 1'b0, code: 2'd0});
    fork
      write_byte(CMD_ENABLE);
      dev_model(11, 1'b1);
      begin
        repeat (200) @(negedge clk);
        check("busy_mid_send", 32'(tx_busy), 32'd1);
        tx_data  = 8'h00;
        tx_write = 1'b1;
        @(negedge clk);
        tx_write = 1'b0;
      end
    join
    wait_idle(3000);
    quiet = 0;
    repeat (100) begin
      @(negedge clk);
      if (ps2_clk_oe) quiet++;
    end
    check("ignored_write_no_restart", quiet, 0);

    // Reset mid-SEND: after 4 clocks of 0x55, d3 = 0 so data is being pulled low
    fork
      write_byte(8'h55);
      dev_model(4, 1'b1);
    join
    check("pre_reset_busy", 32'(tx_busy), 32'd1);
    check("pre_reset_data_oe", 32'(ps2_data_oe), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("mid_reset_data_oe", 32'(ps2_data_oe), 32'd0);
    check("mid_reset_busy", 32'(tx_busy), 32'd0);
    check("mid_reset_pulses", 32'(tx_done | tx_error), 32'd0);
    reset = 1'b0;
    repeat (XTMO + 100) @(negedge clk);

    check("resp_queue_drained", resp_q.size(), 0);
    check("frame_queue_drained", frame_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter, the send side of the keyboard link whose receive side feeds the Orion key matrix. It sends one command or argument byte to the keyboard, such as 0xED followed by an LED mask that drives the RUS/LAT indicator from ind_rus_lat. It uses the standard host request-to-send sequence and checks for the device ACK. It drives the shared PS/2 clock and data lines through open-drain enables, and asserts tx_busy so the receive path can ignore bus activity while a byte is being sent.

Parameters:
INHIBIT_CYC, 4000, clk cycles the clock line is held low before the start bit (100 us at 40 MHz)
START_TMO_CYC, 600000, max clk cycles from clock release to the first device falling edge (15 ms)
XFER_TMO_CYC, 80000, max clk cycles from the first device falling edge to ACK sampled (2 ms)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ps2_clk_i  in  1  raw PS/2 clock line level (asynchronous)
ps2_data_i  in  1  raw PS/2 data line level (asynchronous)
ps2_clk_oe  out  1  1 = pull clock line low; 0 = release
ps2_data_oe  out  1  1 = pull data line low; 0 = release
tx_data  in  8  byte to send
tx_write  in  1  1-cycle request; accepted only in IDLE
tx_busy  out  1  high from acceptance until return to IDLE
tx_done  out  1  1-cycle pulse: byte sent and ACK received
tx_error  out  1  1-cycle pulse: no ACK or timeout
tx_err_code  out  2  valid with tx_error: 1 = start timeout, 2 = transfer timeout, 3 = no ACK; holds last value

Behaviour:
- Reset (synchronous, active-high): all outputs 0, state IDLE, counters 0. Reset mid-transfer releases both lines on the next edge with no pulse.
- Line inputs: 2-FF synchronizer per line, then a falling-edge strobe on the synchronized clock (fall = prev & ~cur).
- Shift register is 9 bits: {odd parity, tx_data}; parity = ~^tx_data.
- IDLE:
  - Both oe = 0.
  - tx_write latches the shift register, sets tx_busy the next cycle, clears cnt → INHIBIT.
  - tx_write in any other state is ignored.
- INHIBIT:
  - clk_oe = 1, data_oe = 0.
  - After INHIBIT_CYC cycles: data_oe = 1 (start bit), then clk_oe = 0 one cycle later → WAIT_FIRST.
- WAIT_FIRST:
  - clk_oe = 0, data_oe = 1.
  - First falling edge: data_oe = ~shift[0], shift right, bitcnt = 1, reset cnt → SEND.
  - START_TMO_CYC elapsed with no edge → ERROR, code 1.
- SEND:
  - On each falling edge with bitcnt 1..8: data_oe = ~shift[0], shift, bitcnt++. This puts out d1..d7, then parity.
  - On the falling edge with bitcnt = 9: data_oe = 0 (stop bit = release), bitcnt = 10 → ACK.
- ACK:
  - Next falling edge: sampled data 0 → WAIT_IDLE; sampled data 1 → ERROR, code 3.
- WAIT_IDLE:
  - Wait until synchronized clk = 1 and data = 1 → DONE.
- Transfer timeout: the XFER_TMO_CYC counter runs from entry to SEND until leaving WAIT_IDLE. Expiry → ERROR, code 2.
- DONE: tx_done = 1 for one cycle → IDLE; tx_busy falls the same edge.
- ERROR: both oe = 0, tx_error = 1 for one cycle, tx_err_code updated → IDLE.
- tx_done and tx_error are never both high.
- Outputs are registered. Data is changed only in the cycle after a detected falling edge, so it is stable for the device's rising-edge sampling.
- Bus timing: a 0xED send takes ≈ INHIBIT + ~11 device clocks (~1.1 ms at 10 kHz).

Decomposition:
- Shared package ps2_pkg:
  - state encoding (IDLE, INHIBIT, WAIT_FIRST, SEND, ACK, WAIT_IDLE, DONE, ERROR)
  - error codes ERR_START = 1, ERR_XFER = 2, ERR_NOACK = 3
  - command constants CMD_SET_LED = 0xED, CMD_ENABLE = 0xF4, CMD_RESET = 0xFF; device replies ACK = 0xFA, RESEND = 0xFE
  - LED bit positions SCROLL = 0, NUM = 1, CAPS = 2
- One sub-module, ps2_line_sync: 2-FF synchronizer plus falling-edge strobe, shared with the receiver.

Test Plan:
- Send 0xED against a device model clocking at 10 kHz that ACKs:
  - clk_oe low for exactly 4000 cycles, data_oe high before clock release;
  - the model captures start 0, data bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1;
  - tx_done pulses once and tx_busy falls the same edge.
- Send 0x02 then 0xFF back-to-back: captured parity is 0, then 1; both end with tx_done.
- Model never clocks: tx_error pulses with tx_err_code = 1 after 600000 cycles from clock release; both oe = 0 afterwards.
- Model clocks but leaves data high at the ACK edge: tx_error with code 3; no tx_done.
- Model stops clocking after 5 bits: tx_error with code 2 at 80000 cycles after the first edge.
- tx_write pulse while in SEND is ignored (the captured byte is unchanged). Reset asserted mid-SEND: next cycle both oe = 0, tx_busy = 0, no pulses.
